// File: rtl/exec_mul_sequencer.sv
// Iterative shift-add MUL controller that borrows the execute-stage ALU adder.
// Optional MUL_EARLY_EXIT_EN: finish RUN as soon as no multiplier bits remain.
module exec_mul_sequencer #(
    parameter int unsigned N       = 64,
    parameter logic [3:0]  ADD_CTL = 4'b0010
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_E,
    input  logic         flush_E,
    input  logic [N-1:0] opA_E,
    input  logic [N-1:0] opB_E,
    input  logic [N-1:0] aluResult_E,
    output logic         aluSel_E,
    output logic [N-1:0] aluA_E,
    output logic [N-1:0] aluB_E,
    output logic [3:0]   aluCtl_E,
    output logic         stall_E,
    output logic         done_E,
    output logic [N-1:0] result_E
);

    localparam int unsigned   CntW    = $clog2(N);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e          state_q;
    logic [N-1:0]    acc_q;
    logic [N-1:0]    mcand_q;
    logic [N-1:0]    mplier_q;
    logic [N-1:0]    result_q;
    logic [CntW-1:0] cnt_q;

    logic [N-1:0]    acc_d;
    logic            last_iter;

    // Accumulator value after this RUN cycle, including the final partial product.
    assign acc_d = mplier_q[0] ? aluResult_E : acc_q;

`ifdef MUL_EARLY_EXIT_EN
    assign last_iter = (cnt_q == CntLast) || ((mplier_q >> 1) == '0);
`else
    assign last_iter = (cnt_q == CntLast);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (flush_E) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_E) begin
                        acc_q    <= '0;
                        mcand_q  <= opA_E;
                        mplier_q <= opB_E;
                        cnt_q    <= '0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (last_iter) begin
                        result_q <= acc_d;
                        state_q  <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // ALU override is only active in RUN so the normal pipeline path is untouched otherwise.
    always_comb begin
        aluSel_E = 1'b0;
        aluA_E   = '0;
        aluB_E   = '0;
        aluCtl_E = 4'b0000;
        stall_E  = 1'b0;
        done_E   = 1'b0;
        case (state_q)
            StIdle: begin
                stall_E = start_E & ~flush_E;
            end
            StRun: begin
                aluSel_E = 1'b1;
                aluA_E   = acc_q;
                aluB_E   = mcand_q;
                aluCtl_E = ADD_CTL;
                stall_E  = ~flush_E;
            end
            StDone: begin
                done_E = ~flush_E;
            end
            default: ;
        endcase
    end

    assign result_E = result_q;

endmodule

// File: tb/tb_exec_mul_sequencer.sv
// Scoreboard bench for exec_mul_sequencer: driver pushes expected products and
// done cycles, an independent monitor pops and compares on every done pulse.
module tb_exec_mul_sequencer;

    localparam int unsigned N       = 64;
    localparam logic [3:0]  ADD_CTL = 4'b0010;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_E;
    logic         flush_E;
    logic [N-1:0] opA_E;
    logic [N-1:0] opB_E;
    logic [N-1:0] aluResult_E;
    logic         aluSel_E;
    logic [N-1:0] aluA_E;
    logic [N-1:0] aluB_E;
    logic [3:0]   aluCtl_E;
    logic         stall_E;
    logic         done_E;
    logic [N-1:0] result_E;

    typedef struct {
        logic [N-1:0] res;
        int           dcyc;
        int           run;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    bit           mon_en = 1'b0;
    logic [N-1:0] last_res = '0;

    exec_mul_sequencer #(.N(N), .ADD_CTL(ADD_CTL)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_E    (start_E),
        .flush_E    (flush_E),
        .opA_E      (opA_E),
        .opB_E      (opB_E),
        .aluResult_E(aluResult_E),
        .aluSel_E   (aluSel_E),
        .aluA_E     (aluA_E),
        .aluB_E     (aluB_E),
        .aluCtl_E   (aluCtl_E),
        .stall_E    (stall_E),
        .done_E     (done_E),
        .result_E   (result_E)
    );

    // Shared ALU stand-in: only ADD yields a sum, anything else is visibly wrong.
    assign aluResult_E = (aluCtl_E == ADD_CTL) ? aluA_E + aluB_E : aluA_E ^ aluB_E;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int run_len(input logic [N-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int m = 0;
        for (int i = 0; i < int'(N); i++) if (b[i]) m = i + 1;
        return (m < 1) ? 1 : m;
`else
        return int'(N);
`endif
    endfunction

    // Monitor: every done pulse must match the oldest expected product.
    initial begin
        exp_t e;
        int   sel_cnt = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (flush_E) sel_cnt = 0;
                else if (aluSel_E) sel_cnt++;
                if (done_E) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 64'(done_E), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        check("result", result_E, e.res);
                        check("done_cycle", 64'(cyc), 64'(e.dcyc));
                        check("alusel_cycles", 64'(sel_cnt), 64'(e.run));
                        last_res = e.res;
                    end
                    sel_cnt = 0;
                end else begin
                    check("result_hold", result_E, last_res);
                end
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
    task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int   sc = 0;
        bit   seen = 1'b0;
        e.res  = a * b;
        e.run  = run_len(b);
        e.dcyc = cyc + e.run + 1;
        sb.push_back(e);
        opA_E   = a;
        opB_E   = b;
        start_E = 1'b1;
        for (int k = 0; k < int'(N) + 20; k++) begin
            @(negedge clk);
            if (stall_E) sc++;
            if (done_E) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            // Re-asserted start and changing operands while busy must be ignored.
            start_E = 1'($urandom_range(0, 1));
            opA_E   = {$urandom, $urandom};
            opB_E   = {$urandom, $urandom};
        end
        check("done_seen", 64'(seen), 64'(1));
        if (!seen) sb.delete();
        check("stall_cycles", 64'(sc), 64'(e.run + 1));
        @(posedge clk);
        #1;
        start_E = 1'b0;
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        reset   = 1'b0;
        start_E = 1'b1;
        flush_E = 1'b0;
        opA_E   = 64'd5;
        opB_E   = 64'd5;
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b1;
        start_E = 1'b0;
        @(negedge clk);
        check("rst_done", 64'(done_E), 64'(0));
        check("rst_alusel", 64'(aluSel_E), 64'(0));
        check("rst_stall", 64'(stall_E), 64'(0));
        check("rst_aluA", aluA_E, 64'(0));
        check("rst_aluB", aluB_E, 64'(0));
        check("rst_aluctl", 64'(aluCtl_E), 64'(0));
        check("rst_result", result_E, 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_after_rst_alusel", 64'(aluSel_E), 64'(0));
        check("idle_after_rst_stall", 64'(stall_E), 64'(0));
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        do_mul(64'd7, 64'd6);
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
        do_mul(64'h8000_0000_0000_0000, 64'd2);
        do_mul(64'd7, 64'd6);

        // Flush ten cycles after start: no done, result keeps the last product.
        opA_E   = 64'd11;
        opB_E   = 64'h8000_0000_0000_0001;
        start_E = 1'b1;
        @(posedge clk);
        #1;
        start_E = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush_E = 1'b1;
        @(negedge clk);
        check("flush_stall", 64'(stall_E), 64'(0));
        check("flush_done", 64'(done_E), 64'(0));
        @(posedge clk);
        #1;
        flush_E = 1'b0;
        @(negedge clk);
        check("post_flush_alusel", 64'(aluSel_E), 64'(0));
        check("post_flush_stall", 64'(stall_E), 64'(0));
        check("post_flush_result", result_E, 64'd42);
        @(posedge clk);
        #1;
        do_mul(64'd13, 64'd17);

        // Start and flush together: stays idle.
        opA_E   = 64'd3;
        opB_E   = 64'd3;
        start_E = 1'b1;
        flush_E = 1'b1;
        @(negedge clk);
        check("startflush_stall", 64'(stall_E), 64'(0));
        @(posedge clk);
        #1;
        start_E = 1'b0;
        flush_E = 1'b0;
        @(negedge clk);
        check("startflush_alusel", 64'(aluSel_E), 64'(0));
        check("startflush_stall_next", 64'(stall_E), 64'(0));
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            a = {$urandom, $urandom};
            case (i % 3)
                0:       b = {$urandom, $urandom};
                1:       b = 64'($urandom_range(0, 20));
                default: b = (i % 2 == 0) ? 64'd0 : 64'd5;
            endcase
            do_mul(a, b);
        end

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_mul_sequencer.md
Name: exec_mul_sequencer

Overview:
- Multi-cycle controller for 64-bit MUL in the execute stage. Multiplication is done by iterative shift-add.
- It borrows the existing execute-stage ALU adder instead of adding a dedicated multiplier. While it owns the ALU, it stalls the pipeline.
- It sits beside the execute stage. A muxed override (aluSel_E) selects its operands and ALU control in place of the normal readData1/ALU-mux path. The product is returned on result_E with a one-cycle done pulse.

Parameters:
- N, 64, operand/result width; also the iteration count.
- ADD_CTL, 4'b0010, AluControl code for ADD, driven onto the shared ALU.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge.
- start_E  in  1  a MUL is in EX with valid operands; meaningful only in IDLE.
- flush_E  in  1  kill the EX instruction; aborts any operation in flight.
- opA_E  in  N  multiplicand (readData1_E).
- opB_E  in  N  multiplier (readData2_E).
- aluResult_E  in  N  result from the shared ALU.
- aluSel_E  out  1  1 = sequencer drives the ALU inputs/control.
- aluA_E  out  N  ALU operand A during RUN.
- aluB_E  out  N  ALU operand B during RUN.
- aluCtl_E  out  4  ALU control during RUN.
- stall_E  out  1  hold IF/ID/EX pipeline registers.
- done_E  out  1  one-cycle pulse: result_E valid.
- result_E  out  N  low N bits of opA*opB; held until the next done.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - acc, mcand, mplier, cnt, result_E are cleared to 0.
  - done_E, aluSel_E and stall_E read 0.
  - aluA_E, aluB_E and aluCtl_E read 0.
  - Reset mid-RUN abandons the operation; no done is produced.
- States: IDLE, RUN, DONE. State register is 2 bits; the unused encoding returns to IDLE.
- IDLE:
  - On start_E=1 and flush_E=0: acc<=0, mcand<=opA_E, mplier<=opB_E, cnt<=0, go to RUN.
  - stall_E is combinational: stall_E = start_E & ~flush_E in IDLE, so the MUL is held in EX from its first cycle.
- RUN:
  - Outputs: aluSel_E=1, aluA_E=acc, aluB_E=mcand, aluCtl_E=ADD_CTL, stall_E=1.
  - Each cycle: if mplier[0], then acc<=aluResult_E; mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
  - When cnt==N-1, go to DONE. The counter is $clog2(N) bits wide.
- DONE:
  - result_E<=acc is loaded on the RUN->DONE edge; done_E=1 for exactly one cycle.
  - stall_E=0 and aluSel_E=0, so the MUL advances to MEM with result_E.
  - Next state is IDLE unconditionally.
- Latency: start at edge t, done_E high in cycle t+N+1 (t+65 for N=64). Throughput is one MUL per N+2 cycles.
- Arithmetic: all adds are modulo 2^N; carry and overflow are ignored. The low N bits are correct for both signed and unsigned operands.
- start_E while in RUN or DONE is ignored. The pipeline is stalled, so the same instruction stays presented. After DONE, the instruction has moved on and start_E reflects the next instruction.
- flush_E=1 in any state:
  - Next state is IDLE; done_E=0 and stall_E=0 in that cycle.
  - result_E keeps its previous value.
  - flush_E wins over start_E in the same cycle.
- aluSel_E=0 outside RUN, so normal ALU operation is bit-identical to the pipeline without this block.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: RUN also goes to DONE when (mplier>>1)==0, i.e. no remaining multiplier bits.
  - RUN lasts max(1, msb_index(opB)+1) cycles.
  - opB=0 gives done at t+2; opB=5 gives done at t+4.
  - result_E is identical to the fixed-latency build.
- Undefined: RUN always lasts exactly N cycles, regardless of operands.

Test Plan:
- Reset held low 3 cycles, then released -> all outputs 0, state IDLE; a start pulsed during reset is ignored.
- opA=7, opB=6, start 1 cycle -> stall_E high t..t+N; done_E only at t+65; result_E=42; aluSel_E high exactly 64 cycles.
- opA=0xFFFFFFFFFFFFFFFF (-1), opB=3 -> result_E=0xFFFFFFFFFFFFFFFD (-3); opA=2^63, opB=2 -> result_E=0 (wrap).
- Start, then flush_E at cycle t+10 -> next cycle IDLE, stall_E=0, no done_E; result_E keeps its prior value (42). A new start at t+12 completes normally.
- Start and flush same cycle in IDLE -> stays IDLE, stall_E=0; start re-asserted during RUN does not restart (done still at t+65).
- MUL_EARLY_EXIT_EN: opA=9, opB=0 -> done at t+2, result 0; opB=5 -> done at t+4, result 45; N=8 build with opA=0xFF, opB=0xFF -> result 0x01.
